// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the fetch/decode/execute controller.
// Imported by the sequencer and its wait-state counter.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        RST,
        IF1,
        IF2,
        UPDATE_PC,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        ALU_B,
        ALU_AB,
        ALU_CMP,
        WB_RD,
        ADDR_CALC,
        LD_ADDR,
        LD_MEM,
        LD_WB,
        GET_RD,
        ST_PASS,
        ST_MEM,
        HALT
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    // {opcode, op} encodings
    localparam logic [4:0] INS_MOV_IMM = 5'b11010;
    localparam logic [4:0] INS_MOV_SH  = 5'b11000;
    localparam logic [4:0] INS_MVN     = 5'b10111;
    localparam logic [4:0] INS_ADD     = 5'b10100;
    localparam logic [4:0] INS_AND     = 5'b10110;
    localparam logic [4:0] INS_CMP     = 5'b10101;
    localparam logic [4:0] INS_LDR     = 5'b01100;
    localparam logic [4:0] INS_STR     = 5'b10000;

    function automatic logic is_halt(input logic [4:0] ins);
        return ins[4:2] == 3'b111;
    endfunction

    function automatic logic is_mem(input logic [4:0] ins);
        return (ins == INS_LDR) || (ins == INS_STR);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_wait_cnt.sv
// Memory wait-state counter shared by instruction fetch and data load.
// done is high once MEM_WAIT stall cycles have elapsed since the last clear.
module ctrl_wait_cnt #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(MEM_WAIT));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Autonomous fetch/decode/execute sequencer for the simple RISC datapath.
// Moore machine: every control output is a function of the current state only.
module cpu_ctrl_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic [1:0] vsel,
    output logic [2:0] nsel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_ir,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    import cpu_ctrl_pkg::*;

    state_t     state;
    state_t     next_state;
    logic [4:0] ins;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_done;

    assign ins = {opcode, op};

    ctrl_wait_cnt #(
        .MEM_WAIT(MEM_WAIT),
        .CNT_W   (CNT_W)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .done(cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        write      = 1'b0;
        vsel       = VSEL_C;
        nsel       = '0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_ir    = 1'b0;
        load_addr  = 1'b0;
        addr_sel   = 1'b0;
        mem_cmd    = MEM_NONE;
        halted     = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;

        case (state)
            RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                next_state = IF1;
            end
            IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                cnt_en   = 1'b1;
                // Counter is cleared on the exit cycle so LD_MEM starts from zero.
                if (cnt_done) begin
                    cnt_clr    = 1'b1;
                    next_state = IF2;
                end
            end
            IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                load_ir    = 1'b1;
                next_state = UPDATE_PC;
            end
            UPDATE_PC: begin
                load_pc    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                if (is_halt(ins)) begin
                    next_state = HALT;
                end else begin
                    case (ins)
                        INS_MOV_IMM:                next_state = WRITE_IMM;
                        INS_MOV_SH, INS_MVN:        next_state = GET_B;
                        INS_ADD, INS_AND, INS_CMP,
                        INS_LDR, INS_STR:           next_state = GET_A;
                        default:                    next_state = IF1;
                    endcase
                end
            end
            WRITE_IMM: begin
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                next_state = IF1;
            end
            GET_A: begin
                nsel       = NSEL_RN;
                loada      = 1'b1;
                next_state = is_mem(ins) ? ADDR_CALC : GET_B;
            end
            GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
                case (ins)
                    INS_MOV_SH, INS_MVN: next_state = ALU_B;
                    INS_CMP:             next_state = ALU_CMP;
                    default:             next_state = ALU_AB;
                endcase
            end
            ALU_B: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = WB_RD;
            end
            ALU_AB: begin
                loadc      = 1'b1;
                next_state = WB_RD;
            end
            ALU_CMP: begin
                loads      = 1'b1;
                next_state = IF1;
            end
            WB_RD: begin
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                next_state = IF1;
            end
            ADDR_CALC: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                next_state = LD_ADDR;
            end
            LD_ADDR: begin
                load_addr  = 1'b1;
                next_state = (ins == INS_LDR) ? LD_MEM : GET_RD;
            end
            LD_MEM: begin
                mem_cmd = MEM_READ;
                cnt_en  = 1'b1;
                if (cnt_done) begin
                    cnt_clr    = 1'b1;
                    next_state = LD_WB;
                end
            end
            LD_WB: begin
                mem_cmd    = MEM_READ;
                nsel       = NSEL_RD;
                vsel       = VSEL_MDATA;
                write      = 1'b1;
                next_state = IF1;
            end
            GET_RD: begin
                nsel       = NSEL_RD;
                loadb      = 1'b1;
                next_state = ST_PASS;
            end
            ST_PASS: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = ST_MEM;
            end
            ST_MEM: begin
                mem_cmd    = MEM_WRITE;
                next_state = IF1;
            end
            HALT: begin
                halted     = 1'b1;
                next_state = HALT;
            end
            default: begin
                next_state = RST;
            end
        endcase
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Next-generation datapath controller for the simple RISC CPU. It replaces the start-pulse driven controller with an autonomous fetch/decode/execute sequencer that drives PC, IR and data-memory control. Over the existing ALU/MOV set it adds LDR, STR, HALT and a parametrised memory wait-state count. It sits between the instruction decoder (opcode/op) and the datapath, PC, IR and memory.

Parameters:
MEM_WAIT, 0, extra stall cycles per memory read beyond the first (0..15)
CNT_W, 4, width of the internal wait counter; must satisfy 2**CNT_W > MEM_WAIT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
opcode  in  3  IR[15:13] from decoder
op  in  2  IR[12:11] from decoder
loada, loadb, loadc, loads  out  1  datapath register enables
asel, bsel  out  1  ALU source selects (asel=1: A:=0; bsel=1: B:=sximm5)
write  out  1  register file write enable
vsel  out  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm
load_pc, reset_pc, load_ir, load_addr, addr_sel  out  1  PC/IR/address control; addr_sel=1 selects PC onto mem_addr
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
halted  out  1  high while in HALT

Behaviour:
- Moore outputs decoded combinationally from state only. Every output not listed for a state is 0 in that state (nsel=000, vsel=00, mem_cmd=NONE).
- rst==0 at a rising edge: state<=RST and wait counter<=0. This overrides everything, including HALT and mid-memory access.
- RST: reset_pc=1, load_pc=1. Next state is IF1.
- IF1: addr_sel=1, mem_cmd=READ. Stays MEM_WAIT cycles using the counter, then goes to IF2. The counter clears on exit.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1. Next state is UPDATE_PC.
- UPDATE_PC: load_pc=1. Next state is DECODE.
- DECODE: no outputs asserted. Dispatch on {opcode,op}:
  - 11010 MOV imm: WRITE_IMM
  - 11000 MOV sh: GET_B
  - 10111 MVN: GET_B
  - 10100 ADD, 10110 AND, 10101 CMP: GET_A
  - 01100 LDR, 10000 STR: GET_A
  - 111xx HALT: HALT
  - any other encoding: IF1 (NOP)
- WRITE_IMM: nsel=001, vsel=10, write=1. Next state is IF1.
- GET_A: nsel=001, loada=1. LDR/STR go to ADDR_CALC; all others go to GET_B.
- GET_B: nsel=100, loadb=1. MOV sh/MVN go to ALU_B; CMP goes to ALU_CMP; ADD/AND go to ALU_AB.
- ALU_B: asel=1, loadc=1. Next state is WB_RD.
- ALU_AB: loadc=1. Next state is WB_RD.
- ALU_CMP: loads=1. Next state is IF1; C is not written.
- WB_RD: nsel=010, vsel=00, write=1. Next state is IF1.
- ADDR_CALC: bsel=1, loadc=1. Next state is LD_ADDR.
- LD_ADDR: load_addr=1. LDR goes to LD_MEM; STR goes to GET_RD.
- LD_MEM: mem_cmd=READ, addr_sel=0. Waits MEM_WAIT cycles as in IF1, then goes to LD_WB.
- LD_WB: mem_cmd=READ, nsel=010, vsel=11, write=1. Next state is IF1.
- GET_RD: nsel=010, loadb=1. Next state is ST_PASS.
- ST_PASS: asel=1, loadc=1. Next state is ST_MEM.
- ST_MEM: mem_cmd=WRITE, addr_sel=0, exactly one cycle. Next state is IF1.
- HALT: halted=1. Self-loop until rst==0.
- Latency with MEM_WAIT=W, counted from the first IF1 cycle to return to IF1:
  - MOV imm: 5+W
  - ADD/AND: 8+W
  - MOV sh/MVN: 7+W
  - CMP: 7+W
  - LDR: 9+2W
  - STR: 10+W
- opcode/op are sampled only in DECODE, GET_A, GET_B and LD_ADDR. The IR is stable across those states.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (RST..HALT)
  - mem_cmd constants MEM_NONE/READ/WRITE
  - vsel constants VSEL_C/PC/IMM/MDATA
  - nsel constants NSEL_RN/RD/RM
  - 5-bit {opcode,op} instruction codes
- One sub-module, ctrl_wait_cnt. Interface: clk, rst, en, clr, done; done=1 when count==MEM_WAIT. It is shared by IF1 and LD_MEM.

Test Plan:
- MEM_WAIT=0, rst=0 one cycle then 1 → reset_pc=load_pc=1 in RST; the next 3 cycles are IF1/IF2/UPDATE_PC with addr_sel=1 and mem_cmd=01, then load_ir=1, then load_pc=1.
- DECODE with {opcode,op}=10100 (ADD) → GET_A (nsel=001, loada), GET_B (nsel=100, loadb), ALU_AB (loadc), WB_RD (nsel=010, write); IF1 again at cycle 8 counted from IF1.
- 10101 (CMP) → loads=1 for exactly one cycle, write never asserted, back to IF1 after 7 cycles.
- MEM_WAIT=2, LDR (01100) → mem_cmd=01 held 3 cycles in IF1 and 3 cycles in LD_MEM; LD_WB asserts vsel=11, nsel=010, write=1; IF1 reached after 13 cycles.
- STR (10000) → load_addr pulses once; ST_MEM asserts mem_cmd=10 and addr_sel=0 for exactly 1 cycle; no write asserted anywhere.
- HALT (11100) → halted=1 held for 20+ cycles with all other outputs 0; rst=0 for one cycle in the middle of LD_MEM or HALT → RST on the next cycle, with the counter restarting from 0 in the following IF1.
